// File: rtl/demux_4_dispatch.sv
// demux_4_dispatch
//
// Routes a single WIDTH-bit operand stream to one of four destination ports.
// The destination is chosen by a 2-bit select that travels with each beat.
// This is the issue-side inverse of a 4:1 operand mux. It holds one
// registered entry, and every port uses valid/ready handshakes.
//
// Handshake rule (input and every output port): a beat transfers on a rising
// edge exactly when valid and ready are both high in the cycle before that
// edge. A producer holds valid and its payload stable until the transfer.
// in_ready is combinational from state, flush and out_ready only.
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst        asynchronous active-high reset
//   S          destination select, captured with in_data on input handshake
//   in_data    operand to dispatch
//   in_valid   in_data/S valid
//   in_ready   block can accept a beat this cycle
//   flush      synchronous drop of the held entry (highest priority)
//   out0..3    per-port registered data
//   out_valid  one-hot (or zero) per-port valid
//   out_ready  per-port consumer ready
//   cnt0..3    per-port delivered-beat counters
//
// Build option: define DEMUX_4_DISPATCH_CNT_EN to implement the per-port
// counters. Without it, cnt0..cnt3 are tied to zero and no counter flops
// exist.

module demux_4_dispatch #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state;
    logic [1:0]       sel_q;
    logic [3:0]       valid_q;
    logic [WIDTH-1:0] data_q [4];

    logic sel_ready;
    logic accept;

    // Consumer ready of the port that currently holds the entry. The other
    // ready bits are ignored.
    assign sel_ready = out_ready[sel_q];

    // In FULL, the held entry drains in the same cycle that a new beat is
    // accepted. This gives one beat per cycle with no bubble.
    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            if (state == ST_EMPTY) in_ready = 1'b1;
            else                   in_ready = sel_ready;
        end
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_EMPTY;
            sel_q   <= 2'd0;
            valid_q <= 4'b0000;
            for (int k = 0; k < 4; k++) data_q[k] <= '0;
        end else if (flush) begin
            // The entry is dropped. The data registers keep their contents.
            state   <= ST_EMPTY;
            valid_q <= 4'b0000;
        end else if (accept) begin
            state     <= ST_FULL;
            sel_q     <= S;
            valid_q   <= 4'b0001 << S;
            data_q[S] <= in_data;
        end else if (state == ST_FULL && sel_ready) begin
            state   <= ST_EMPTY;
            valid_q <= 4'b0000;
        end
    end

    assign out_valid = valid_q;
    assign out0      = data_q[0];
    assign out1      = data_q[1];
    assign out2      = data_q[2];
    assign out3      = data_q[3];

`ifdef DEMUX_4_DISPATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic             out_hs;

    // A flushed entry never counts, even if its consumer was ready.
    assign out_hs = (state == ST_FULL) && sel_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else if (out_hs) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + 1'b1;
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
    assign cnt2 = '0;
    assign cnt3 = '0;
`endif

endmodule
